// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl
// Reads data-memory cells 0..CELDAS-1 one word at a time. Each 16-bit word
// goes to a UART transmitter as two bytes, high byte first. Before the next
// byte is sent, the block waits for the transmitter's byte-complete pulse.
//
// Ports
//   i_clk       single clock, rising edge
//   i_reset     asynchronous, active-low reset
//   i_start     dump request, only looked at while idle
//   o_Rd        one-cycle read strobe to data memory
//   o_Addr      data-memory address (the current cell counter)
//   i_MemData   data-memory read word
//   o_tx_data   byte presented to the UART transmitter
//   o_tx_start  one-cycle byte-send pulse
//   i_tx_done   transmitter byte-complete pulse
//   o_busy      high outside IDLE; selects this block onto the memory port
//   o_done      one-cycle pulse once the last byte has completed
//
// state   | meaning
// IDLE    | waiting for i_start
// READ    | o_Rd high for one cycle; memory answers on the falling edge
// LATCH   | memory word captured into word_q
// SEND_HI | o_tx_start with the high byte
// WAIT_HI | high byte held until i_tx_done
// SEND_LO | o_tx_start with the low byte
// WAIT_LO | low byte held until i_tx_done
// NEXT    | last cell -> DONE, otherwise advance the address and read again
// DONE    | o_done for one cycle
module mem_dump_ctrl #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int CELDAS  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_Rd,
  output logic [NBITS_O-1:0] o_Addr,
  input  logic [NBITS_D-1:0] i_MemData,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [3:0] {
    IDLE,
    READ,
    LATCH,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO,
    NEXT,
    DONE
  } state_t;

  localparam logic [NBITS_O-1:0] LAST_ADDR = NBITS_O'(CELDAS - 1);

  state_t               state_q, state_d;
  logic [NBITS_O-1:0]   addr_q, addr_d;
  logic [NBITS_D-1:0]   word_q, word_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          state_d = READ;
        end
      end
      READ:    state_d = LATCH;
      LATCH: begin
        word_d  = i_MemData;
        state_d = SEND_HI;
      end
      SEND_HI: state_d = WAIT_HI;
      WAIT_HI: if (i_tx_done) state_d = SEND_LO;
      SEND_LO: state_d = WAIT_LO;
      WAIT_LO: if (i_tx_done) state_d = NEXT;
      NEXT: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = READ;
        end
      end
      DONE: begin
        // Park the address at 0 so the idle memory port sees the reset value.
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is decoded from registered state only, so the inputs
  // i_start and i_tx_done have no combinational path to any output.
  always_comb begin
    o_Rd       = (state_q == READ);
    o_Addr     = addr_q;
    o_tx_start = (state_q == SEND_HI) || (state_q == SEND_LO);
    o_busy     = (state_q != IDLE);
    o_done     = (state_q == DONE);
    case (state_q)
      SEND_HI, WAIT_HI: o_tx_data = word_q[15:8];
      SEND_LO, WAIT_LO: o_tx_data = word_q[7:0];
      default:          o_tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
module tb_mem_dump_ctrl;

  localparam int NO = 11;
  localparam int ND = 16;
  localparam int NC = 10;

  logic          i_clk;
  logic          i_reset;
  logic          i_start;
  logic          o_Rd;
  logic [NO-1:0] o_Addr;
  logic [ND-1:0] i_MemData;
  logic [7:0]    o_tx_data;
  logic          o_tx_start;
  logic          i_tx_done;
  logic          o_busy;
  logic          o_done;

  logic resp_done;
  logic spur;
  assign i_tx_done = resp_done | spur;

  mem_dump_ctrl #(.NBITS_O(NO), .NBITS_D(ND), .CELDAS(NC)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .o_Rd       (o_Rd),
    .o_Addr     (o_Addr),
    .i_MemData  (i_MemData),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge i_clk) cyc++;

  // Data memory: answers a read strobe on the falling edge.
  logic [15:0] mem [0:2047];
  always @(negedge i_clk) if (o_Rd) i_MemData = mem[o_Addr];

  // Transmitter: byte-complete pulse tx_lat cycles after each send pulse.
  int tx_lat  = 3;
  bit tx_hold = 0;
  int rcnt    = 0;
  always @(negedge i_clk) begin
    resp_done = 1'b0;
    if (!i_reset) rcnt = 0;
    else begin
      if (rcnt > 0 && !tx_hold) begin
        rcnt--;
        if (rcnt == 0) resp_done = 1'b1;
      end
      if (o_tx_start) rcnt = tx_lat;
    end
  end

  // Model: the expected byte stream is simply hi,lo of each memory word in
  // address order, and reads must walk addresses 0,1,2,... once each.
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int exp_addr, rd_cnt, done_cnt;
  bit pend, fresh;
  logic [7:0] held;
  logic txd_at_edge;

  always @(posedge i_clk) txd_at_edge <= i_tx_done;

  task automatic arm();
    exp_q.delete();
    got.delete();
    for (int a = 0; a < NC; a++) begin
      exp_q.push_back(mem[a][15:8]);
      exp_q.push_back(mem[a][7:0]);
    end
    exp_addr = 0;
    rd_cnt   = 0;
    done_cnt = 0;
  endtask

  always @(negedge i_clk) begin
    if (!i_reset) begin
      pend  = 0;
      fresh = 0;
    end else begin
      if (pend && !fresh && txd_at_edge) pend = 0;
      fresh = 0;
      if (o_Rd) begin
        rd_cnt++;
        chk("rd_in_range", (exp_addr < NC), 1);
        chk("rd_addr", 32'(o_Addr), exp_addr);
        chk("rd_while_tx", pend, 0);
        exp_addr++;
      end
      if (o_tx_start) begin
        chk("tx_overlap", pend, 0);
        if (exp_q.size() == 0) chk("tx_extra_byte", 1, 0);
        else chk("tx_byte", o_tx_data, exp_q.pop_front());
        got.push_back(o_tx_data);
        held  = o_tx_data;
        pend  = 1;
        fresh = 1;
      end else if (pend) begin
        chk("tx_hold", o_tx_data, held);
      end
      if (o_done) begin
        done_cnt++;
        chk("done_bytes_left", exp_q.size(), 0);
        chk("done_reads", exp_addr, NC);
        chk("done_busy", o_busy, 1);
      end
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at_cyc);
    bit hit = 0;
    at_cyc = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (done_cnt > 0) begin
        hit = 1;
        at_cyc = cyc;
      end
    end
    if (!hit) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (got.size() >= n) hit = 1;
      else tick();
    end
    if (!hit) chk("wait_bytes_timeout", got.size(), n);
  endtask

  logic [7:0] lit_a [20] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
                             8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07,
                             8'h00, 8'h08, 8'h00, 8'h09};
  logic [15:0] tbl_b [10] = '{16'hBEEF, 16'h1234, 16'hFF00, 16'h00FF, 16'h8001,
                              16'h5AA5, 16'hC3C3, 16'h0F0F, 16'h7E81, 16'hDEAD};

  int t_done, a0;

  initial begin
    i_reset = 1'b0;
    i_start = 1'b0;
    spur    = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    repeat (3) tick();
    chk("rst_busy",     o_busy, 0);
    chk("rst_rd",       o_Rd, 0);
    chk("rst_addr",     32'(o_Addr), 0);
    chk("rst_tx_data",  o_tx_data, 0);
    chk("rst_tx_start", o_tx_start, 0);
    chk("rst_done",     o_done, 0);
    i_reset = 1'b1;
    tick();

    // A: cells hold 0..9, spurious tx_done in IDLE and READ.
    for (int i = 0; i < NC; i++) mem[i] = 16'(i);
    arm();
    tx_lat = 3;
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_spur_busy", o_busy, 0);
    end
    start_pulse();
    chk("a_read", {o_Rd, o_tx_start, o_busy}, 3'b101);
    tick();
    spur = 1'b0;
    chk("a_latch", {o_Rd, o_tx_start, o_busy}, 3'b001);
    tick();
    chk("a_send_hi", {o_Rd, o_tx_start, o_busy}, 3'b011);
    wait_done(600, t_done);
    chk("a_nbytes", got.size(), 20);
    for (int k = 0; k < 20 && k < got.size(); k++) chk("a_lit_byte", got[k], lit_a[k]);
    chk("a_reads", rd_cnt, 10);
    repeat (5) tick();
    chk("a_done_once", done_cnt, 1);
    chk("a_idle_after", o_busy, 0);

    // B: transmitter stalls 50 cycles during the first high byte.
    for (int i = 0; i < NC; i++) mem[i] = tbl_b[i];
    arm();
    tx_hold = 1;
    start_pulse();
    wait_bytes(1, 20);
    repeat (50) tick();
    chk("b_stall_bytes", got.size(), 1);
    chk("b_stall_busy", o_busy, 1);
    chk("b_stall_data", o_tx_data, 8'hBE);
    tx_hold = 0;
    wait_done(600, t_done);
    chk("b_nbytes", got.size(), 20);
    if (got.size() >= 2) begin
      chk("b_byte0", got[0], 8'hBE);
      chk("b_byte1", got[1], 8'hEF);
    end
    tick();

    // C: i_start re-pulsed while busy.
    for (int i = 0; i < NC; i++) mem[i] = 16'h1000 + 16'(i) * 16'h0101;
    arm();
    start_pulse();
    wait_bytes(5, 100);
    start_pulse();
    wait_done(600, t_done);
    repeat (20) tick();
    chk("c_nbytes", got.size(), 20);
    chk("c_done_once", done_cnt, 1);
    chk("c_reads", rd_cnt, 10);
    chk("c_no_restart", o_busy, 0);

    // D: asynchronous reset during WAIT_LO of address 4.
    for (int i = 0; i < NC; i++) mem[i] = 16'hA0B0 + 16'(i);
    arm();
    start_pulse();
    wait_bytes(10, 200);
    tick();
    chk("d_pre_addr", 32'(o_Addr), 4);
    chk("d_pre_data", o_tx_data, 8'hB4);
    i_reset = 1'b0;
    #1;
    chk("d_rst_busy",     o_busy, 0);
    chk("d_rst_rd",       o_Rd, 0);
    chk("d_rst_addr",     32'(o_Addr), 0);
    chk("d_rst_tx_data",  o_tx_data, 0);
    chk("d_rst_tx_start", o_tx_start, 0);
    chk("d_rst_done",     o_done, 0);
    tick();
    i_reset = 1'b1;
    repeat (5) tick();
    chk("d_no_done", done_cnt, 0);
    chk("d_idle", o_busy, 0);
    arm();
    start_pulse();
    wait_done(600, t_done);
    chk("d_nbytes", got.size(), 20);
    if (got.size() >= 2) begin
      chk("d_byte0", got[0], 8'hA0);
      chk("d_byte1", got[1], 8'hB0);
    end
    tick();

    // E: zero-wait transmitter, timing from start edge to o_done.
    for (int i = 0; i < NC; i++) mem[i] = 16'(i);
    arm();
    tx_lat = 1;
    a0 = cyc;
    start_pulse();
    wait_done(200, t_done);
    chk("e_done_cycle", t_done - a0, 7 * NC + 1);
    chk("e_done_cycle_lit", t_done - a0, 71);
    chk("e_reads", rd_cnt, 10);
    chk("e_nbytes", got.size(), 20);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_dump_ctrl.md
MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 The block SHALL have parameter NBITS_O, default 11, meaning the data-memory address width.
REQ-002 The block SHALL have parameter NBITS_D, default 16, meaning the data-memory word width; only 16 is supported, giving two bytes per word.
REQ-003 The block SHALL have parameter CELDAS, default 10, meaning the number of cells dumped, from address 0 to CELDAS-1.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_start, input, 1 bit: dump request, sampled in IDLE only.
REQ-007 The block SHALL have port o_Rd, output, 1 bit: read strobe to data memory.
REQ-008 The block SHALL have port o_Addr, output, NBITS_O bits: data-memory address.
REQ-009 The block SHALL have port i_MemData, input, NBITS_D bits: data-memory read word.
REQ-010 The block SHALL have port o_tx_data, output, 8 bits: byte to the UART transmitter.
REQ-011 The block SHALL have port o_tx_start, output, 1 bit: one-cycle byte-send pulse.
REQ-012 The block SHALL have port i_tx_done, input, 1 bit: transmitter byte-complete pulse.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE; it is the memory-port mux select, and o_Wr to memory is held 0 by the mux while it is high.
REQ-014 The block SHALL have port o_done, output, 1 bit: one-cycle pulse at dump end.

Function
REQ-015 The FSM SHALL have states IDLE, READ, LATCH, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, NEXT and DONE.
REQ-016 In IDLE, i_start=1 SHALL load the address counter with 0 and go to READ; otherwise the FSM stays in IDLE.
REQ-017 READ SHALL drive o_Rd=1 for exactly one cycle with o_Addr=counter, then go to LATCH; memory updates on the falling edge inside this cycle.
REQ-018 LATCH SHALL capture i_MemData into an internal word register on its rising edge, then go to SEND_HI; o_Addr is held at the counter value throughout.
REQ-019 SEND_HI SHALL drive o_tx_data=word[15:8] and o_tx_start=1 for one cycle, then go to WAIT_HI.
REQ-020 WAIT_HI SHALL hold o_tx_data until i_tx_done=1, then go to SEND_LO; i_tx_done in any other state SHALL be ignored.
REQ-021 SEND_LO and WAIT_LO SHALL behave as SEND_HI and WAIT_HI using word[7:0], then go to NEXT.
REQ-022 NEXT SHALL go to DONE if counter==CELDAS-1; otherwise it SHALL increment the counter and go to READ, with no wrap past CELDAS-1.
REQ-023 DONE SHALL assert o_done=1 for one cycle, then go to IDLE.
REQ-024 i_start while o_busy=1 SHALL be ignored and SHALL NOT restart the dump or queue a second dump.
REQ-025 With zero tx wait, one word SHALL take 7 cycles (READ through NEXT); the full dump SHALL take 7*CELDAS+1 cycles from the start edge to o_done.
REQ-026 Outputs SHALL be registered or decoded from state only, with no combinational path from i_tx_done or i_start.

Reset
REQ-027 i_reset=0 SHALL immediately force IDLE, counter=0, word=0, o_Rd=0, o_Addr=0, o_tx_data=0, o_tx_start=0, o_busy=0 and o_done=0.
REQ-028 Reset mid-dump SHALL abandon the dump with no o_done, and the next i_start SHALL restart from address 0.

Verification
REQ-029 Memory holding 0..9 plus i_start pulse, tx_done 3 cycles after each start -> 20 bytes 00,00,00,01,...,00,09 in order, then one o_done pulse.
REQ-030 i_tx_done held 0 for 50 cycles in WAIT_HI -> FSM stays put, o_tx_data stable, no further o_tx_start.
REQ-031 i_start re-pulsed at byte 5 -> stream unchanged, exactly 20 bytes, one o_done.
REQ-032 i_reset=0 asynchronously during WAIT_LO of address 4 -> all outputs 0 before the next clock edge; a new i_start restarts at address 0.
REQ-033 Spurious i_tx_done in IDLE and READ -> ignored, no state change.
REQ-034 Zero-latency tx_done, with i_tx_done=1 on the cycle after each o_tx_start -> o_done at cycle 71 (7*CELDAS+1) after the start edge, and o_Rd high exactly 10 times.
